io_timer: RTL

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_timer_if.sv | 15 +
 rtl/io_timer.sv | 117 +++++++++++
 2 files changed

// File: rtl/io_timer_if.sv
// rtl/io_timer_if.sv - register bus and interrupt bundle between bridge and io_timer
interface io_timer_if;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        irq;

    modport master (output sel, output addr, output we, output wd, output be,
                    input rd, input irq);
    modport slave  (input sel, input addr, input we, input wd, input be,
                    output rd, output irq);
endinterface

// File: rtl/io_timer.sv
// rtl/io_timer.sv - down-counting interval timer with one-shot/auto-reload modes and irq
// Optional 8-bit prescaler at offset 3 when TIMER_PRESCALE_EN is defined.
module io_timer #(
    parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    io_timer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ctrl, ctrl_nxt;
    logic [31:0] preset, preset_merged;
    logic [31:0] count, count_nxt;
    logic        pend, pend_nxt;
    logic        tick;
    logic        wr;
    logic [31:0] prescale_rd;
    logic [31:0] rd_val;

    assign wr = bus.sel & bus.we;

    always_comb begin
        preset_merged = preset;
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) preset_merged[8*i +: 8] = bus.wd[8*i +: 8];
        end
    end

`ifdef TIMER_PRESCALE_EN
    logic [7:0] prescale, div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale <= 8'h0;
            div      <= 8'h0;
        end else begin
            if (wr && bus.addr == 2'd3 && bus.be[0]) prescale <= bus.wd[7:0];
            if (state == CNT) div <= (div == prescale) ? 8'h0 : div + 8'h1;
            else              div <= 8'h0;
        end
    end

    assign tick        = (div == prescale);
    assign prescale_rd = {24'h0, prescale};
`else
    assign tick        = 1'b1;
    assign prescale_rd = 32'h0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ctrl   <= 4'h0;
            preset <= RESET_PRESET;
            count  <= 32'h0;
            pend   <= 1'b0;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_nxt;
            count <= count_nxt;
            pend  <= pend_nxt;
            if (wr && bus.addr == 2'd1) preset <= preset_merged;
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl_nxt  = ctrl;
        count_nxt = count;
        pend_nxt  = pend;
        case (state)
            IDLE: if (ctrl[0]) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[0])          state_nxt = IDLE;
                else if (tick) begin
                    if (count != 32'h0) count_nxt = count - 32'h1;
                    else                state_nxt = INT;
                end
            end
            INT: begin
                if (ctrl[2:1] == 2'b01) begin
                    count_nxt = preset;
                    pend_nxt  = 1'b0;
                    state_nxt = CNT;
                end else begin
                    ctrl_nxt[0] = 1'b0;
                    state_nxt   = IDLE;
                end
            end
        endcase
        // Software CTRL write beats the hardware EN clear; a fresh expiry beats the pend clear.
        if (wr && bus.addr == 2'd0) begin
            pend_nxt = 1'b0;
            if (bus.be[0]) ctrl_nxt = bus.wd[3:0];
        end
        if (state == CNT && ctrl[0] && tick && count == 32'h0) pend_nxt = 1'b1;
    end

    always_comb begin
        rd_val = 32'h0;
        case (bus.addr)
            2'd0: rd_val = {28'h0, ctrl};
            2'd1: rd_val = preset;
            2'd2: rd_val = count;
            2'd3: rd_val = prescale_rd;
        endcase
    end

    assign bus.rd  = bus.sel ? rd_val : 32'h0;
    assign bus.irq = ctrl[3] & pend;
endmodule
